data_port_arbiter: RTL and testbench

Two-requester arbiter for the single data port of the instruction/data memory: the CPU data interface (port 0) and a secondary master such as a program loader or DMA engine (port 1). The block sits between both requesters and the memory's data-side read address, write address, write data and write enable. It grants one requester per cycle using round-robin priority. A requester may hold the port for a bounded locked burst.

---
 rtl/data_port_arbiter.sv | 90 +++++++++
 tb/tb_data_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/data_port_arbiter.sv
// Round-robin arbiter for the shared instruction/data memory data port, with
// bounded locked bursts so one master can stream without being interleaved.
module data_port_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [1:0]        lock_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic             r_rr_ptr;
    logic             r_locked;
    logic             r_lock_owner;
    logic [CNT_W-1:0] r_burst_cnt;

    logic             w_lock_hold;
    logic [1:0]       w_gnt;
    logic             w_xfer;
    logic             w_port;
    logic [CNT_W-1:0] w_cnt_eff;

    assign w_lock_hold = r_locked & req_i[r_lock_owner];

    // Reset gates the grant so nothing reaches memory while rst is high.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            if (w_lock_hold)
                w_gnt[r_lock_owner] = 1'b1;
            else if (req_i[r_rr_ptr])
                w_gnt[r_rr_ptr] = 1'b1;
            else if (req_i[~r_rr_ptr])
                w_gnt[~r_rr_ptr] = 1'b1;
        end
    end

    assign w_xfer = |w_gnt;
    assign w_port = w_gnt[1];

    // An abandoned lock's count must not carry over into a new lock by the other port.
    assign w_cnt_eff = w_lock_hold ? r_burst_cnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= 1'b0;
            r_locked     <= 1'b0;
            r_lock_owner <= 1'b0;
            r_burst_cnt  <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= ~w_port;
            if (lock_i[w_port] && (w_cnt_eff < CNT_LAST)) begin
                r_locked     <= 1'b1;
                r_lock_owner <= w_port;
                r_burst_cnt  <= w_cnt_eff + 1'b1;
            end else begin
                r_locked    <= 1'b0;
                r_burst_cnt <= '0;
            end
        end else if (r_locked && !req_i[r_lock_owner]) begin
            r_locked    <= 1'b0;
            r_burst_cnt <= '0;
        end
    end

    assign gnt_o       = w_gnt;
    assign mem_addr_o  = w_port ? addr1_i : addr0_i;
    assign mem_wdata_o = w_port ? wdata1_i : wdata0_i;
    assign mem_write_o = w_xfer & we_i[w_port];
    assign rdata_o     = mem_rdata_i;
    assign busy_o      = r_locked;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed table-driven bench for data_port_arbiter (MAX_BURST = 4).
module tb_data_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_i, we_i, lock_i;
    logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i;
    logic [1:0]  gnt_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic        mem_write_o, busy_o;

    int total = 0;
    int bad   = 0;

    data_port_arbiter #(.MAX_BURST(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .gnt_o(gnt_o), .rdata_o(rdata_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_write_o(mem_write_o),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] we;
        logic [1:0] lock;
        logic [1:0] gnt;
        logic       wr;
        logic       busy;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [1:0] req, input logic [1:0] we,
                        input logic [1:0] lock, input logic [1:0] gnt,
                        input logic wr, input logic busy);
        vecs[i].req  = req;
        vecs[i].we   = we;
        vecs[i].lock = lock;
        vecs[i].gnt  = gnt;
        vecs[i].wr   = wr;
        vecs[i].busy = busy;
    endtask

    initial begin
        logic [31:0] exp_addr, exp_wdata;

        // Plain alternation
        setv(0,  2'b11, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
        setv(1,  2'b11, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
        setv(2,  2'b11, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
        setv(3,  2'b11, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
        // Single requester writing
        setv(4,  2'b10, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
        setv(5,  2'b10, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
        setv(6,  2'b10, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
        // Hand priority to port 1, then burst to the limit
        setv(7,  2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
        setv(8,  2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1);
        setv(9,  2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1);
        setv(10, 2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1);
        setv(11, 2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0);
        setv(12, 2'b11, 2'b00, 2'b10, 2'b01, 1'b0, 1'b0);
        setv(13, 2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1);
        // Lock abandonment after two locked transfers
        setv(14, 2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1);
        setv(15, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
        // Read/write gating
        setv(16, 2'b01, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0);
        setv(17, 2'b11, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0);
        setv(18, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        // Start a port 1 lock for the async reset check
        setv(19, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1);

        rst = 1'b1; req_i = 2'b11; we_i = 2'b11; lock_i = 2'b00;
        addr0_i = 32'h10; addr1_i = 32'h40;
        wdata0_i = 32'h0000_AAAA; wdata1_i = 32'hDEAD_BEEF;
        mem_rdata_i = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",   32'(gnt_o), 32'(2'b00));
        chk("rst_write", 32'(mem_write_o), 32'(1'b0));
        chk("rst_busy",  32'(busy_o), 32'(1'b0));

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            req_i  = vecs[i].req;
            we_i   = vecs[i].we;
            lock_i = vecs[i].lock;
            mem_rdata_i = (i == 16) ? 32'h1234 : 32'h1200 + 32'(i);
            exp_addr  = vecs[i].gnt[1] ? 32'h40 : 32'h10;
            exp_wdata = vecs[i].gnt[1] ? 32'hDEAD_BEEF : 32'h0000_AAAA;
            #2;
            chk($sformatf("v%0d_gnt", i),   32'(gnt_o), 32'(vecs[i].gnt));
            chk($sformatf("v%0d_write", i), 32'(mem_write_o), 32'(vecs[i].wr));
            chk($sformatf("v%0d_addr", i),  mem_addr_o, exp_addr);
            chk($sformatf("v%0d_wdata", i), mem_wdata_o, exp_wdata);
            chk($sformatf("v%0d_rdata", i), rdata_o, mem_rdata_i);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy", i),  32'(busy_o), 32'(vecs[i].busy));
            $display("vec %0d req=%b we=%b lock=%b gnt=%b wr=%b busy=%b",
                     i, req_i, we_i, lock_i, gnt_o, mem_write_o, busy_o);
        end

        // Asynchronous reset between edges while port 1 holds the lock
        #2;
        we_i = 2'b11;
        rst  = 1'b1;
        #1;
        chk("async_busy",  32'(busy_o), 32'(1'b0));
        chk("async_gnt",   32'(gnt_o), 32'(2'b00));
        chk("async_write", 32'(mem_write_o), 32'(1'b0));
        @(posedge clk);
        #1;
        chk("async_busy_hold", 32'(busy_o), 32'(1'b0));
        req_i = 2'b11; we_i = 2'b00; lock_i = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_gnt", 32'(gnt_o), 32'(2'b01));
        $display("async reset seq gnt=%b busy=%b", gnt_o, busy_o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
